// File: rtl/volt_mon_pkg.sv
// volt_mon_pkg: band codes, default thresholds and LED bit positions shared by the voltage band monitor.
package volt_mon_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        LOW   = 3'd1,
        UNDER = 3'd2,
        OK    = 3'd3,
        OVER  = 3'd4
    } band_t;

    localparam logic [15:0] DEF_TH_LOW   = 16'h0860;
    localparam logic [15:0] DEF_TH_OK_LO = 16'h08B0;
    localparam logic [15:0] DEF_TH_OK_HI = 16'h0C0C;
    localparam logic [15:0] DEF_HYST     = 16'h0010;

    localparam int LED_OVER  = 0;
    localparam int LED_OK    = 1;
    localparam int LED_UNDER = 2;
    localparam int LED_LOW   = 3;
    localparam int LED_FAULT = 4;

    // Active-high one-hot of the band LEDs; ZERO lights nothing.
    function automatic logic [3:0] band_leds(band_t b);
        logic [3:0] m;
        m = '0;
        m[LED_OVER]  = b == OVER;
        m[LED_OK]    = b == OK;
        m[LED_UNDER] = b == UNDER;
        m[LED_LOW]   = b == LOW;
        return m;
    endfunction

endpackage

// File: rtl/volt_avg_acc.sv
// volt_avg_acc: post-reset blanking gate and block averager over 2**AVG_LOG2 samples.
module volt_avg_acc
    import volt_mon_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AVG_LOG2  = 3,
    parameter int BLANK_CYC = 65535
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic [DW-1:0] volt,
    input  logic          volt_vld,
    output logic [DW-1:0] avg_volt,
    output logic          avg_vld
);

    localparam int SW = DW + AVG_LOG2;
    localparam int BW = $clog2(BLANK_CYC + 2);

    logic [BW-1:0]       blank_cnt;
    logic [SW-1:0]       sum, sum_nxt;
    logic [AVG_LOG2-1:0] cnt;
    logic                live;

    assign live    = blank_cnt == BW'(BLANK_CYC);
    assign sum_nxt = sum + SW'(volt);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blank_cnt <= '0;
            sum       <= '0;
            cnt       <= '0;
            avg_volt  <= '0;
            avg_vld   <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (!live) begin
                blank_cnt <= blank_cnt + BW'(1);
            end else if (volt_vld) begin
                // sample counter wraps to zero on the last sample of a block
                cnt <= cnt + AVG_LOG2'(1);
                sum <= &cnt ? '0 : sum_nxt;
                if (&cnt) begin
                    avg_volt <= sum_nxt[SW-1:AVG_LOG2];
                    avg_vld  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/volt_band_monitor.sv
// volt_band_monitor: classifies block-averaged ADC samples into voltage bands with hysteresis and
// N-consecutive confirmation, latches over-voltage faults and drives status LEDs and the output enable.
module volt_band_monitor
    import volt_mon_pkg::*;
#(
    parameter int            DW        = 16,
    parameter int            AVG_LOG2  = 3,
    parameter int            CONFIRM   = 4,
    parameter int            BLANK_CYC = 65535,
    parameter logic [DW-1:0] TH_LOW    = DW'(DEF_TH_LOW),
    parameter logic [DW-1:0] TH_OK_LO  = DW'(DEF_TH_OK_LO),
    parameter logic [DW-1:0] TH_OK_HI  = DW'(DEF_TH_OK_HI),
    parameter logic [DW-1:0] HYST      = DW'(DEF_HYST)
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic [DW-1:0] volt,
    input  logic          volt_vld,
    input  logic          clr_fault,
    output logic [DW-1:0] avg_volt,
    output logic          avg_vld,
    output logic [2:0]    band,
    output logic          fault,
    output logic [4:0]    led_n,
    output logic          enable_out
);

    localparam int CW = $clog2(CONFIRM + 1);

    band_t         band_q, cand, raw, cls, lo, hi;
    logic [CW-1:0] conf_cnt, conf_nxt;
    logic [DW-1:0] bnd;
    logic          adj, near, fault_nxt;

    volt_avg_acc #(
        .DW        (DW),
        .AVG_LOG2  (AVG_LOG2),
        .BLANK_CYC (BLANK_CYC)
    ) u_acc (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .volt      (volt),
        .volt_vld  (volt_vld),
        .avg_volt  (avg_volt),
        .avg_vld   (avg_vld)
    );

    // Hysteresis only applies between neighbouring non-ZERO bands, around their shared threshold.
    always_comb begin
        raw = avg_volt == '0 ? ZERO : avg_volt <= TH_LOW ? LOW : avg_volt <= TH_OK_LO ? UNDER :
              avg_volt <= TH_OK_HI ? OK : OVER;
        lo = raw < band_q ? raw : band_q;
        hi = raw < band_q ? band_q : raw;
        bnd = lo == LOW ? TH_LOW : lo == UNDER ? TH_OK_LO : TH_OK_HI;
        adj = lo != ZERO && 3'(hi) == 3'(lo) + 3'd1;
        near = {1'b0, avg_volt} + {1'b0, HYST} >= {1'b0, bnd} &&
               {1'b0, avg_volt} <= {1'b0, bnd} + {1'b0, HYST};
        cls = adj && near ? band_q : raw;
        conf_nxt = cls == cand ? conf_cnt + CW'(1) : CW'(1);
        fault_nxt = band_q == OVER || (fault && !clr_fault);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            band_q     <= ZERO;
            cand       <= ZERO;
            conf_cnt   <= '0;
            fault      <= 1'b0;
            led_n      <= 5'h1F;
            enable_out <= 1'b0;
        end else begin
            if (avg_vld) begin
                if (cls == band_q) begin
                    conf_cnt <= '0;
                end else if (conf_nxt >= CW'(CONFIRM)) begin
                    band_q   <= cls;
                    cand     <= cls;
                    conf_cnt <= '0;
                end else begin
                    cand     <= cls;
                    conf_cnt <= conf_nxt;
                end
            end
            fault      <= fault_nxt;
            led_n      <= {~fault_nxt, ~band_leds(band_q)};
            enable_out <= band_q == OK && !fault_nxt;
        end
    end

    assign band = band_q;

endmodule

// File: tb/tb_volt_band_monitor.sv
// tb_volt_band_monitor: scenario table with hand-derived expectations, reset/blanking sequences,
// and randomized blocks checked against a band/confirmation reference model.
module tb_volt_band_monitor;

    localparam int BLANK   = 100;
    localparam int CONFIRM = 4;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] volt = '0;
    logic        volt_vld = 1'b0;
    logic        clr_fault = 1'b0;
    logic [15:0] avg_volt;
    logic        avg_vld;
    logic [2:0]  band;
    logic        fault;
    logic [4:0]  led_n;
    logic        enable_out;

    volt_band_monitor #(.BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .volt       (volt),
        .volt_vld   (volt_vld),
        .clr_fault  (clr_fault),
        .avg_volt   (avg_volt),
        .avg_vld    (avg_vld),
        .band       (band),
        .fault      (fault),
        .led_n      (led_n),
        .enable_out (enable_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [2:0]  band;
        logic [4:0]  led;
        logic        en;
        logic        flt;
    } vec_t;

    vec_t        tbl[26];
    logic [15:0] samp[8];
    int          total = 0;
    int          bad = 0;
    int          m_band = 0;
    bit          m_fault = 1'b0;
    int          hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic setv(input int i, input logic [15:0] b, input logic [15:0] s, input logic [2:0] bd,
                        input logic [4:0] l, input logic e, input logic f);
        tbl[i].base = b;
        tbl[i].step = s;
        tbl[i].band = bd;
        tbl[i].led  = l;
        tbl[i].en   = e;
        tbl[i].flt  = f;
    endtask

    function automatic int raw_of(input int v);
        return v == 0 ? 0 : v <= 'h0860 ? 1 : v <= 'h08B0 ? 2 : v <= 'h0C0C ? 3 : 4;
    endfunction

    function automatic int th_of(input int b);
        return b == 1 ? 'h0860 : b == 2 ? 'h08B0 : 'h0C0C;
    endfunction

    // Commit when the last CONFIRM classified averages since the last commit agree on a new band.
    task automatic model_block(input int avg);
        int r, c, b;
        bit same;
        r = raw_of(avg);
        c = r;
        if (r != 0 && m_band != 0 && (r - m_band == 1 || m_band - r == 1)) begin
            b = th_of(r < m_band ? r : m_band);
            if (avg >= b - 16 && avg <= b + 16) c = m_band;
        end
        hist.push_back(c);
        if (hist.size() > CONFIRM) void'(hist.pop_front());
        if (hist.size() == CONFIRM && c != m_band) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != c) same = 1'b0;
            if (same) begin
                m_band = c;
                hist.delete();
            end
        end
        if (m_band == 4) m_fault = 1'b1;
    endtask

    function automatic logic [4:0] exp_led();
        logic [3:0] oh;
        oh = m_band == 0 ? 4'b0000 : 4'b1000 >> (m_band - 1);
        return {~m_fault, ~oh};
    endfunction

    task automatic run_block();
        int sum, avg, pb;
        bit early;
        sum = 0;
        early = 1'b0;
        pb = m_band;
        for (int i = 0; i < 8; i++) begin
            volt = samp[i];
            volt_vld = 1'b1;
            sum += int'(samp[i]);
            @(negedge clk);
            volt_vld = 1'b0;
            if (i < 7) begin
                early |= avg_vld;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    early |= avg_vld;
                end
            end
        end
        avg = sum / 8;
        chk("avg_vld_early", early, 0);
        chk("avg_vld", avg_vld, 1);
        chk("avg_volt", avg_volt, avg);
        chk("band_hold", band, pb);
        model_block(avg);
        @(negedge clk);
        chk("avg_vld_pulse", avg_vld, 0);
        chk("band", band, m_band);
        @(negedge clk);
        chk("led_n", led_n, exp_led());
        chk("fault", fault, m_fault);
        chk("enable_out", enable_out, m_band == 3 && !m_fault);
    endtask

    task automatic play(input int k);
        for (int i = 0; i < 8; i++) samp[i] = tbl[k].base + tbl[k].step * 16'(i);
        run_block();
        chk("tbl_band", band, tbl[k].band);
        chk("tbl_led", led_n, tbl[k].led);
        chk("tbl_en", enable_out, tbl[k].en);
        chk("tbl_fault", fault, tbl[k].flt);
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        if (m_band != 4) m_fault = 1'b0;
        chk("clr_fault", fault, m_fault);
        chk("clr_en", enable_out, m_band == 3 && !m_fault);
        chk("clr_led4", led_n[4], !m_fault);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_avg_volt"}, avg_volt, 0);
        chk({nm, "_avg_vld"}, avg_vld, 0);
        chk({nm, "_band"}, band, 0);
        chk({nm, "_fault"}, fault, 0);
        chk({nm, "_led"}, led_n, 5'h1F);
        chk({nm, "_en"}, enable_out, 0);
    endtask

    task automatic blank_phase(input logic [15:0] v);
        bit seen;
        seen = 1'b0;
        volt = v;
        repeat (BLANK - 10) begin
            volt_vld = 1'b1;
            @(negedge clk);
            seen |= avg_vld;
        end
        volt_vld = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= avg_vld;
        end
        chk("blank_avg_vld", seen, 0);
        chk("blank_led", led_n, 5'h1F);
        chk("blank_en", enable_out, 0);
        chk("blank_band", band, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int cat, reps, c;
        setv(0, 16'h0A00, 16'd2, 3'd0, 5'h1F, 1'b0, 1'b0);
        setv(1, 16'h0000, 16'd0, 3'd0, 5'h1F, 1'b0, 1'b0);
        for (int i = 2; i < 5; i++) setv(i, 16'h0A00, 16'd0, 3'd0, 5'h1F, 1'b0, 1'b0);
        setv(5, 16'h0A00, 16'd0, 3'd3, 5'b11101, 1'b1, 1'b0);
        for (int i = 6; i < 10; i++) setv(i, 16'h08A8, 16'd0, 3'd3, 5'b11101, 1'b1, 1'b0);
        for (int i = 10; i < 13; i++) setv(i, 16'h0890, 16'd0, 3'd3, 5'b11101, 1'b1, 1'b0);
        setv(13, 16'h0890, 16'd0, 3'd2, 5'b11011, 1'b0, 1'b0);
        for (int i = 14; i < 17; i++) setv(i, 16'h0D00, 16'd0, 3'd2, 5'b11011, 1'b0, 1'b0);
        setv(17, 16'h0D00, 16'd0, 3'd4, 5'b01110, 1'b0, 1'b1);
        for (int i = 18; i < 21; i++) setv(i, 16'h0A00, 16'd0, 3'd4, 5'b01110, 1'b0, 1'b1);
        setv(21, 16'h0A00, 16'd0, 3'd3, 5'b01101, 1'b0, 1'b1);
        for (int i = 22; i < 25; i++) setv(i, 16'h0D00, 16'd0, 3'd3, 5'b11101, 1'b1, 1'b0);
        setv(25, 16'h0D00, 16'd0, 3'd4, 5'b01110, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk_reset("rst");
        sys_rst_n = 1'b1;
        blank_phase(16'h0A00);

        for (int k = 0; k < 22; k++) begin
            play(k);
            if (k == 0) chk("avg_first", avg_volt, 16'h0A07);
        end
        pulse_clr();
        chk("clr_fault_hand", fault, 0);
        chk("clr_en_hand", enable_out, 1);
        for (int k = 22; k < 26; k++) play(k);
        pulse_clr();
        chk("clr_over_fault", fault, 1);
        chk("clr_over_en", enable_out, 0);

        for (int i = 0; i < 5; i++) begin
            volt = 16'h0100;
            volt_vld = 1'b1;
            @(negedge clk);
        end
        volt_vld = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1 chk_reset("midrst");
        m_band = 0;
        m_fault = 1'b0;
        hist.delete();
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        blank_phase(16'h0300);
        for (int i = 0; i < 8; i++) samp[i] = 16'h0A00;
        run_block();
        chk("post_rst_avg", avg_volt, 16'h0A00);

        for (int k = 0; k < 40; k++) begin
            cat = int'($urandom_range(0, 6));
            reps = int'($urandom_range(1, 5));
            c = cat == 0 ? 0 : cat == 1 ? 'h0400 : cat == 2 ? 'h0860 : cat == 3 ? 'h08B0 :
                cat == 4 ? 'h0C0C : cat == 5 ? 'h0A00 : 'h0E00;
            if (cat >= 2 && cat <= 4) c = c + int'($urandom_range(0, 48)) - 24;
            repeat (reps) begin
                for (int i = 0; i < 8; i++) samp[i] = cat == 0 ? 16'h0000 : 16'(c + int'($urandom_range(0, 3)));
                run_block();
            end
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/volt_band_monitor.md
Name: volt_band_monitor

Overview:
- Sits directly downstream of the serial ADC reader. Consumes its 16-bit `volt` conversion results and produces the board's status indication and output-enable decision.
- Block-averages samples, then classifies each average into a voltage band with hysteresis and N-consecutive confirmation.
- Drives active-low status LEDs and `enable_out`, the gate for the pulse generators.
- Latches over-voltage faults until explicitly cleared.

Parameters:
- DW, 16, sample width.
- AVG_LOG2, 3, log2 of samples per average (8).
- CONFIRM, 4, consecutive identical out-of-band averages needed to commit a band change.
- BLANK_CYC, 65535, clk cycles after reset during which samples are ignored.
- TH_LOW, 16'h0860, upper bound of LOW band.
- TH_OK_LO, 16'h08B0, upper bound of UNDER band.
- TH_OK_HI, 16'h0C0C, upper bound of OK band.
- HYST, 16'h0010, hysteresis margin around each boundary.

Ports:
- clk  in  1  system clock (50 MHz).
- sys_rst_n  in  1  asynchronous active-low reset.
- volt  in  DW  ADC conversion result.
- volt_vld  in  1  one-cycle strobe; `volt` is valid while it is high.
- clr_fault  in  1  one-cycle request to clear the over-voltage latch.
- avg_volt  out  DW  latest block average.
- avg_vld  out  1  one-cycle strobe when `avg_volt` updates.
- band  out  3  committed band code.
- fault  out  1  over-voltage latch.
- led_n  out  5  active-low LEDs:
  - [0] OVER, [1] OK, [2] UNDER, [3] LOW, [4] fault.
- enable_out  out  1  output-stage enable.

Behaviour:
- Reset values (asynchronous on `sys_rst_n` low):
  - `avg_volt=0`, `avg_vld=0`, `band=ZERO`, `fault=0`, `led_n=5'h1F`, `enable_out=0`.
  - Blanking counter, accumulator, sample counter, candidate band and confirm counter all cleared.
- Blanking:
  - Counter runs from 0 and saturates at BLANK_CYC.
  - While it is below BLANK_CYC, `volt_vld` is ignored and all outputs hold their reset values.
- Averaging:
  - Accumulator width is DW+AVG_LOG2, so it cannot overflow.
  - Each accepted `volt_vld` adds `volt` and increments the sample counter.
  - On the 2^AVG_LOG2-th sample: `avg_volt = (sum + volt) >> AVG_LOG2` (truncating), and `avg_vld` pulses on the next clk (latency 1). The accumulator and counter restart from 0 in that same cycle.
  - The average is block-based, not moving.
- Raw band from `avg_volt` (codes from package):
  - ZERO when v == 0.
  - LOW when 0 < v ≤ TH_LOW.
  - UNDER when TH_LOW < v ≤ TH_OK_LO.
  - OK when TH_OK_LO < v ≤ TH_OK_HI.
  - OVER when v > TH_OK_HI.
- Hysteresis:
  - If the raw band is adjacent to the committed band and v lies within HYST of their shared boundary, the raw band is forced to the committed band.
  - The comparison is inclusive of boundary ± HYST.
  - ZERO never gets hysteresis.
- Confirmation, evaluated once per `avg_vld`:
  - raw == committed → confirm counter = 0.
  - raw != committed and raw == candidate → counter increments. When it reaches CONFIRM, committed band = candidate and counter = 0.
  - Otherwise candidate = raw and counter = 1.
  - With CONFIRM=1 a change commits immediately.
- Committed-band update:
  - `band` updates 1 clk after the deciding `avg_vld`.
  - `led_n`, `fault` and `enable_out` update 1 clk after `band`.
  - `led_n[3:0]` has exactly one bit low for LOW/UNDER/OK/OVER, and all bits high for ZERO.
- Fault latch:
  - Set when `band == OVER`; set has priority over clear.
  - `clr_fault` clears it only when `band != OVER`.
  - `led_n[4] = ~fault`.
- `enable_out = (band == OK) && !fault`.
- Reset mid-operation discards the partial sum and restarts blanking. There is no partial-average output.

Decomposition:
- Shared package `volt_mon_pkg`:
  - Band code constants: ZERO=0, LOW=1, UNDER=2, OK=3, OVER=4.
  - Default threshold constants.
  - LED bit index constants.
- One sub-module `volt_avg_acc`: blanking gate, accumulator, sample counter and the `avg_volt`/`avg_vld` register.
- Classification, confirmation, fault latch and LED decode stay in the top of the block.

Test Plan:
Run with BLANK_CYC=100 and defaults otherwise.
1. Blanking: `volt_vld` strobes with 0x0A00 during the first 100 cycles → `avg_vld` never pulses, `led_n=5'h1F`, `enable_out=0`.
2. Averaging: after blanking, feed 8 samples 0x0A00,0x0A02,...,0x0A0E → `avg_volt=0x0A07`, `avg_vld` high exactly 1 clk after the 8th strobe, second block accumulates from 0.
3. Confirmation: blocks averaging 0x0A00 → `band` stays ZERO after blocks 1–3; after block 4 `band=3`, `led_n=5'b11101`, and `enable_out=1` one cycle later.
4. Hysteresis: from OK, 4 blocks averaging 0x08A8 → `band` stays OK; then 4 blocks at 0x0890 → `band=UNDER`, `led_n=5'b11011`, `enable_out=0`.
5. Fault: 4 blocks at 0x0D00 → `band=OVER`, `fault=1`, `led_n=5'b01110`.
   - Then 4 blocks at 0x0A00 → `band=OK`, `enable_out` still 0.
   - `clr_fault` pulse → `fault=0`, `enable_out=1` next cycle.
   - `clr_fault` asserted while still OVER → no effect.
6. Reset mid-block: drop `sys_rst_n` after 5 of 8 samples → all outputs return to reset values immediately and blanking restarts. The next average uses only the 8 post-blanking samples.
